ball_motion: RTL

Ball engine for the two-player pong datapath. Sits directly upstream and downstream of the two paddle instances. It produces `ball_x`/`ball_y`, which the paddles use for hit detection, and consumes their `tophit`/`midhit`/`bothit` flags to change the ball's velocity. It also handles wall bounces, scoring, serve sequencing and the ball's pixel colour for the VGA mixer.

---
 rtl/pong_pkg.sv | 19 +
 rtl/ball_sprite.sv | 27 ++
 rtl/ball_motion.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong datapath: playfield geometry, ball FSM
// states and the signed velocity type used by the ball engine.
package pong_pkg;

   localparam int BALL_SIZE    = 10;
   localparam int TOP_BOUND    = 136;
   localparam int BOTTOM_BOUND = 512;
   localparam int LEFT_LIMIT   = 5;
   localparam int RIGHT_LIMIT  = 794;

   typedef enum logic [1:0] {
      SERVE  = 2'd0,
      MOVE   = 2'd1,
      SCORED = 2'd2
   } ball_state_t;

   typedef logic signed [3:0] vel_t;

endpackage

// File: rtl/ball_sprite.sv
// Ball sprite: combinational overlap test of the current VGA pixel against
// the BALL_SIZE x BALL_SIZE square whose top-left corner is (ball_x, ball_y).
module ball_sprite
#(
   parameter int          BALL_SIZE = 10,
   parameter logic [11:0] COLOR     = 12'hfff
)(
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic [9:0]  ball_x,
   input  logic [9:0]  ball_y,
   output logic [11:0] rgb
);

   localparam logic [10:0] SIZE_U = 11'(BALL_SIZE);

   logic in_x;
   logic in_y;

   // Widen to 11 bits so the far edge never wraps near the right of the frame.
   always_comb begin
      in_x = ({1'b0, x} >= {1'b0, ball_x}) && ({1'b0, x} < ({1'b0, ball_x} + SIZE_U));
      in_y = ({1'b0, y} >= {1'b0, ball_y}) && ({1'b0, y} < ({1'b0, ball_y} + SIZE_U));
      rgb  = (in_x && in_y) ? COLOR : 12'h000;
   end

endmodule

// File: rtl/ball_motion.sv
// Ball engine: serve sequencing, paddle and wall bounces, scoring with a
// post-score pause, and the ball sprite colour for the VGA mixer.
module ball_motion
   import pong_pkg::*;
#(
   parameter int          BALL_SIZE    = pong_pkg::BALL_SIZE,
   parameter int          XSPEED       = 3,
   parameter int          YSPEED       = 2,
   parameter int          TOP_BOUND    = pong_pkg::TOP_BOUND,
   parameter int          BOTTOM_BOUND = pong_pkg::BOTTOM_BOUND,
   parameter int          LEFT_LIMIT   = pong_pkg::LEFT_LIMIT,
   parameter int          RIGHT_LIMIT  = pong_pkg::RIGHT_LIMIT,
   parameter int          CENTER_X     = 395,
   parameter int          CENTER_Y     = 319,
   parameter int          PAUSE_FRAMES = 60,
   parameter logic [11:0] COLOR        = 12'hfff
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic        serve,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        l_tophit,
   input  logic        l_midhit,
   input  logic        l_bothit,
   input  logic        r_tophit,
   input  logic        r_midhit,
   input  logic        r_bothit,
   output logic [9:0]  ball_x,
   output logic [9:0]  ball_y,
   output logic        score_l,
   output logic        score_r,
   output logic        in_play,
   output logic [11:0] rgb
);

   localparam vel_t              XS      = vel_t'(XSPEED);
   localparam vel_t              YS      = vel_t'(YSPEED);
   localparam logic [9:0]        CX      = 10'(CENTER_X);
   localparam logic [9:0]        CY      = 10'(CENTER_Y);
   localparam logic [9:0]        TOP_U   = 10'(TOP_BOUND);
   localparam logic [9:0]        BOT_U   = 10'(BOTTOM_BOUND - BALL_SIZE);
   localparam logic signed [10:0] TOP_S   = 11'(TOP_BOUND);
   localparam logic signed [10:0] BOTTOM_S = 11'(BOTTOM_BOUND);
   localparam logic signed [10:0] LEFT_S  = 11'(LEFT_LIMIT);
   localparam logic signed [10:0] RIGHT_S = 11'(RIGHT_LIMIT);
   localparam logic signed [10:0] SIZE_S  = 11'(BALL_SIZE);
   localparam logic [7:0]        CNT_END = 8'(PAUSE_FRAMES - 1);

   ball_state_t state, state_nx;
   vel_t        vx, vx_nx, vx_h;
   vel_t        vy, vy_nx, vy_h;
   logic [7:0]  cnt, cnt_nx;
   logic [9:0]  bx_nx, by_nx;
   logic        sl_nx, sr_nx;
   logic        l_acc, r_acc;
   logic signed [10:0] ny, nx;

   // Next-state and datapath: paddle hit, then vertical walls, then horizontal scoring.
   always_comb begin
      state_nx = state;
      bx_nx    = ball_x;
      by_nx    = ball_y;
      vx_nx    = vx;
      vy_nx    = vy;
      cnt_nx   = cnt;
      sl_nx    = 1'b0;
      sr_nx    = 1'b0;

      // Direction gating rejects flags that linger while the ball is still
      // overlapping a paddle it has just bounced off.
      l_acc = (vx < 0) && (l_tophit || l_midhit || l_bothit);
      r_acc = (vx > 0) && (r_tophit || r_midhit || r_bothit);
      vx_h  = vx;
      vy_h  = vy;
      if (l_acc) begin
         vx_h = -vx;
         if (l_tophit)      vy_h = -YS;
         else if (l_midhit) vy_h = '0;
         else               vy_h = YS;
      end else if (r_acc) begin
         vx_h = -vx;
         if (r_tophit)      vy_h = -YS;
         else if (r_midhit) vy_h = '0;
         else               vy_h = YS;
      end

      ny = $signed({1'b0, ball_y}) + $signed({{7{vy_h[3]}}, vy_h});
      nx = $signed({1'b0, ball_x}) + $signed({{7{vx_h[3]}}, vx_h});

      case (state)
         SERVE: begin
            bx_nx = CX;
            by_nx = CY;
            if (serve) state_nx = MOVE;
         end
         MOVE: begin
            if (en) begin
               vx_nx = vx_h;
               vy_nx = vy_h;
               if (ny <= TOP_S) begin
                  by_nx = TOP_U;
                  vy_nx = -vy_h;
               end else if ((ny + SIZE_S) >= BOTTOM_S) begin
                  by_nx = BOT_U;
                  vy_nx = -vy_h;
               end else begin
                  by_nx = ny[9:0];
               end
               // On a score the ball freezes where it was; the relaunch
               // heads toward the player who conceded.
               if (nx <= LEFT_S) begin
                  sr_nx    = 1'b1;
                  state_nx = SCORED;
                  vx_nx    = -XS;
                  bx_nx    = ball_x;
                  by_nx    = ball_y;
               end else if ((nx + SIZE_S) >= RIGHT_S) begin
                  sl_nx    = 1'b1;
                  state_nx = SCORED;
                  vx_nx    = XS;
                  bx_nx    = ball_x;
                  by_nx    = ball_y;
               end else begin
                  bx_nx = nx[9:0];
               end
            end
         end
         SCORED: begin
            if (en) begin
               if (cnt == CNT_END) begin
                  state_nx = SERVE;
                  bx_nx    = CX;
                  by_nx    = CY;
                  vy_nx    = '0;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 8'd1;
               end
            end
         end
         default: state_nx = SERVE;
      endcase
   end

   // State, position, velocity, pause counter and score pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= SERVE;
         ball_x  <= CX;
         ball_y  <= CY;
         vx      <= XS;
         vy      <= '0;
         cnt     <= '0;
         score_l <= 1'b0;
         score_r <= 1'b0;
      end else begin
         state   <= state_nx;
         ball_x  <= bx_nx;
         ball_y  <= by_nx;
         vx      <= vx_nx;
         vy      <= vy_nx;
         cnt     <= cnt_nx;
         score_l <= sl_nx;
         score_r <= sr_nx;
      end
   end

   assign in_play = (state == MOVE);

   ball_sprite #(
      .BALL_SIZE (BALL_SIZE),
      .COLOR     (COLOR)
   ) u_sprite (
      .x      (x),
      .y      (y),
      .ball_x (ball_x),
      .ball_y (ball_y),
      .rgb    (rgb)
   );

endmodule
